// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch/pre-decode widths and the instruction-queue entry layout.
// Macros stay visible to every file compiled after this one.
`ifndef RISCV_DEFINE_V
`define RISCV_DEFINE_V
`define INST_WIDTH      32
`define INST_ADDR_WIDTH 32
`define BP_GHR_BITS     8
`define IF_BATCH_SIZE   2
`endif

`ifndef IQ_DEPTH
`define IQ_DEPTH 8
`endif

`define IQ_ENTRY_WIDTH (`INST_WIDTH + 1 + `INST_ADDR_WIDTH + `BP_GHR_BITS)

package fetch_inst_queue_pkg;

    localparam int INST_W = `INST_WIDTH;
    localparam int ADDR_W = `INST_ADDR_WIDTH;
    localparam int GHR_W  = `BP_GHR_BITS;
    localparam int ENTRY_W = `IQ_ENTRY_WIDTH;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [GHR_W-1:0]  hist;
    } iq_entry_t;

    // A predicted-taken slot 0 ends the fetch group, so slot 1 is wrong-path.
    function automatic logic slot1_kept(input logic [1:0] valid, input logic taken_0);
        return valid[1] & ~(valid[0] & taken_0);
    endfunction

endpackage

// File: rtl/fetch_iq_ram.sv
// Instruction-queue storage: register array with two write and two async read ports.
module fetch_iq_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 73
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_0,
    input  logic [$clog2(DEPTH)-1:0] waddr_0,
    input  logic [WIDTH-1:0]         wdata_0,
    input  logic                     we_1,
    input  logic [$clog2(DEPTH)-1:0] waddr_1,
    input  logic [WIDTH-1:0]         wdata_1,
    input  logic [$clog2(DEPTH)-1:0] raddr_0,
    output logic [WIDTH-1:0]         rdata_0,
    input  logic [$clog2(DEPTH)-1:0] raddr_1,
    output logic [WIDTH-1:0]         rdata_1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The two write addresses are always consecutive, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (we_0) mem[waddr_0] <= wdata_0;
            if (we_1) mem[waddr_1] <= wdata_1;
        end
    end

    assign rdata_0 = mem[raddr_0];
    assign rdata_1 = mem[raddr_1];

endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch-to-pre-decode decoupling queue: 2-wide push with taken-branch compaction,
// 2-wide show-ahead pop, flush to empty.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = `IQ_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [`IF_BATCH_SIZE-1:0]   in_valid,
    input  logic [`INST_WIDTH-1:0]      in_inst_0,
    input  logic [`INST_WIDTH-1:0]      in_inst_1,
    input  logic                        in_pred_taken_0,
    input  logic                        in_pred_taken_1,
    input  logic [`INST_ADDR_WIDTH-1:0] in_pred_target_0,
    input  logic [`INST_ADDR_WIDTH-1:0] in_pred_target_1,
    input  logic [`BP_GHR_BITS-1:0]     in_pred_hist_0,
    input  logic [`BP_GHR_BITS-1:0]     in_pred_hist_1,
    output logic                        in_ready,
    input  logic                        dec_stall,
    output logic [1:0]                  out_inst_valid,
    output logic [`INST_WIDTH-1:0]      out_inst_0,
    output logic [`INST_WIDTH-1:0]      out_inst_1,
    output logic                        out_pred_taken_0,
    output logic                        out_pred_taken_1,
    output logic [`INST_ADDR_WIDTH-1:0] out_pred_target_0,
    output logic [`INST_ADDR_WIDTH-1:0] out_pred_target_1,
    output logic [`BP_GHR_BITS-1:0]     out_pred_hist_0,
    output logic [`BP_GHR_BITS-1:0]     out_pred_hist_1,
    output logic [$clog2(DEPTH):0]      out_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    iq_entry_t     in_e0, in_e1, wdata_0, rd_0, rd_1;
    logic          push_acc, we_0, we_1;
    logic [1:0]    n_push, n_pop;

    assign in_e0 = '{inst: in_inst_0, taken: in_pred_taken_0,
                     target: in_pred_target_0, hist: in_pred_hist_0};
    assign in_e1 = '{inst: in_inst_1, taken: in_pred_taken_1,
                     target: in_pred_target_1, hist: in_pred_hist_1};

    // Pre-pop occupancy only: space freed by this cycle's pop is not reused.
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign push_acc = in_ready & (|in_valid) & ~flush;

    assign we_0    = push_acc;
    assign we_1    = push_acc & in_valid[0] & slot1_kept(in_valid, in_pred_taken_0);
    assign wdata_0 = in_valid[0] ? in_e0 : in_e1;
    assign n_push  = push_acc ? (we_1 ? 2'd2 : 2'd1) : 2'd0;

    always_comb begin
        n_pop = 2'd0;
        if (!dec_stall && !flush) begin
            if (count >= CW'(2)) n_pop = 2'd2;
            else                 n_pop = count[1:0];
        end
    end

    assign out_inst_valid = {n_pop == 2'd2, n_pop != 2'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_pop);
            tail  <= tail + AW'(n_push);
            count <= count + CW'(n_push) - CW'(n_pop);
        end
    end

    fetch_iq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_0    (we_0),
        .waddr_0 (tail),
        .wdata_0 (wdata_0),
        .we_1    (we_1),
        .waddr_1 (tail + AW'(1)),
        .wdata_1 (in_e1),
        .raddr_0 (head),
        .rdata_0 (rd_0),
        .raddr_1 (head + AW'(1)),
        .rdata_1 (rd_1)
    );

    assign out_inst_0        = out_inst_valid[0] ? rd_0.inst   : '0;
    assign out_pred_taken_0  = out_inst_valid[0] ? rd_0.taken  : 1'b0;
    assign out_pred_target_0 = out_inst_valid[0] ? rd_0.target : '0;
    assign out_pred_hist_0   = out_inst_valid[0] ? rd_0.hist   : '0;
    assign out_inst_1        = out_inst_valid[1] ? rd_1.inst   : '0;
    assign out_pred_taken_1  = out_inst_valid[1] ? rd_1.taken  : 1'b0;
    assign out_pred_target_1 = out_inst_valid[1] ? rd_1.target : '0;
    assign out_pred_hist_1   = out_inst_valid[1] ? rd_1.hist   : '0;

    assign out_count = count;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Self-checking bench for fetch_inst_queue: vector table plus scoreboard of accepted entries.
module tb_fetch_inst_queue;
    import fetch_inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [31:0] in_inst_0 = '0, in_inst_1 = '0;
    logic        in_pred_taken_0 = 1'b0, in_pred_taken_1 = 1'b0;
    logic [31:0] in_pred_target_0 = '0, in_pred_target_1 = '0;
    logic [7:0]  in_pred_hist_0 = '0, in_pred_hist_1 = '0;
    logic        in_ready;
    logic        dec_stall = 1'b0;
    logic [1:0]  out_inst_valid;
    logic [31:0] out_inst_0, out_inst_1;
    logic        out_pred_taken_0, out_pred_taken_1;
    logic [31:0] out_pred_target_0, out_pred_target_1;
    logic [7:0]  out_pred_hist_0, out_pred_hist_1;
    logic [3:0]  out_count;

    int n_cmp = 0;
    int n_bad = 0;
    iq_entry_t q[$];

    always #5 clk = ~clk;

    fetch_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_inst_0(in_inst_0), .in_inst_1(in_inst_1),
        .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
        .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
        .in_pred_hist_0(in_pred_hist_0), .in_pred_hist_1(in_pred_hist_1),
        .in_ready(in_ready), .dec_stall(dec_stall), .out_inst_valid(out_inst_valid),
        .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
        .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
        .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
        .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1),
        .out_count(out_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic iq_entry_t mk(input logic [31:0] inst, input logic tk, input logic [31:0] tgt);
        return '{inst: inst, taken: tk, target: tgt, hist: inst[7:0] ^ 8'h5a};
    endfunction

    // Called at a falling edge; drives one cycle, checks against the model, advances.
    task automatic step(input logic [1:0] v, input iq_entry_t e0, input iq_entry_t e1,
                        input logic st, input logic fl,
                        input logic use_exp, input int exp_cnt, input logic [1:0] exp_ov);
        int        n;
        logic      m_ready;
        iq_entry_t a0, a1, x;
        in_valid = v;
        in_inst_0 = e0.inst; in_pred_taken_0 = e0.taken;
        in_pred_target_0 = e0.target; in_pred_hist_0 = e0.hist;
        in_inst_1 = e1.inst; in_pred_taken_1 = e1.taken;
        in_pred_target_1 = e1.target; in_pred_hist_1 = e1.hist;
        dec_stall = st;
        flush = fl;
        #1;
        m_ready = (DEPTH - q.size()) >= 2;
        chk("in_ready", 128'(in_ready), 128'(m_ready));
        chk("out_count", 128'(out_count), 128'(q.size()));
        n = (st || fl) ? 0 : ((q.size() >= 2) ? 2 : q.size());
        chk("out_inst_valid", 128'(out_inst_valid), 128'({n == 2, n >= 1}));
        if (use_exp) begin
            chk("vec_count", 128'(out_count), 128'(exp_cnt));
            chk("vec_valid", 128'(out_inst_valid), 128'(exp_ov));
        end
        a0 = '{inst: out_inst_0, taken: out_pred_taken_0, target: out_pred_target_0, hist: out_pred_hist_0};
        a1 = '{inst: out_inst_1, taken: out_pred_taken_1, target: out_pred_target_1, hist: out_pred_hist_1};
        x = (n >= 1) ? q.pop_front() : '0;
        chk("slot0", 128'(a0), 128'(x));
        x = (n == 2) ? q.pop_front() : '0;
        chk("slot1", 128'(a1), 128'(x));
        if (m_ready && (v != 2'b00) && !fl) begin
            if (v[0]) q.push_back(e0);
            if (v[1] && !(v[0] && e0.taken)) q.push_back(e1);
        end
        if (fl) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] i0, i1;
        logic        tk0;
        logic [31:0] tgt0;
        logic        stall;
        int          exp_cnt;
        logic [1:0]  exp_ov;
    } vec_t;

    vec_t vecs[9];
    iq_entry_t z;

    initial begin
        z = '0;
        vecs[0] = '{2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 2'b00};
        vecs[1] = '{2'b11, 32'hA000_0001, 32'hB000_0002, 1'b0, 32'h0, 1'b0, 0, 2'b00};
        vecs[2] = '{2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2, 2'b11};
        vecs[3] = '{2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 2'b00};
        vecs[4] = '{2'b11, 32'hD000_0003, 32'hE000_0004, 1'b1, 32'h100, 1'b1, 0, 2'b00};
        vecs[5] = '{2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 2'b01};
        vecs[6] = '{2'b10, 32'h0, 32'hC000_0005, 1'b0, 32'h0, 1'b0, 0, 2'b00};
        vecs[7] = '{2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 2'b01};
        vecs[8] = '{2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 2'b00};

        #1;
        chk("rst_count", 128'(out_count), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_valid", 128'(out_inst_valid), 128'(0));
        chk("rst_inst0", 128'(out_inst_0), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            step(vecs[i].valid, mk(vecs[i].i0, vecs[i].tk0, vecs[i].tgt0),
                 mk(vecs[i].i1, 1'b0, 32'h0), vecs[i].stall, 1'b0,
                 1'b1, vecs[i].exp_cnt, vecs[i].exp_ov);

        // Fill to full under stall, then drain in order.
        for (int i = 0; i < 4; i++)
            step(2'b11, mk(32'h1000 + 2*i, 1'b0, 32'h40 + i), mk(32'h1001 + 2*i, 1'b1, 32'h80 + i),
                 1'b1, 1'b0, 1'b1, 2*i, 2'b00);
        #1;
        chk("full_count", 128'(out_count), 128'(8));
        chk("full_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        step(2'b11, mk(32'hDEAD, 1'b0, 32'h0), mk(32'hBEEF, 1'b0, 32'h0), 1'b1, 1'b0, 1'b1, 8, 2'b00);
        for (int i = 0; i < 4; i++)
            step(2'b00, z, z, 1'b0, 1'b0, 1'b1, 8 - 2*i, 2'b11);

        // count = DEPTH-1 refuses a batch.
        for (int i = 0; i < 3; i++)
            step(2'b11, mk(32'h2000 + i, 1'b0, 32'h0), mk(32'h2100 + i, 1'b0, 32'h0),
                 1'b1, 1'b0, 1'b1, 2*i, 2'b00);
        step(2'b01, mk(32'h2200, 1'b0, 32'h0), z, 1'b1, 1'b0, 1'b1, 6, 2'b00);
        step(2'b11, mk(32'h2300, 1'b0, 32'h0), mk(32'h2301, 1'b0, 32'h0), 1'b1, 1'b0, 1'b1, 7, 2'b00);
        for (int i = 0; i < 4; i++)
            step(2'b00, z, z, 1'b0, 1'b0, 1'b0, 0, 2'b00);

        // Flush at count 5 together with a push.
        step(2'b11, mk(32'h3000, 1'b0, 32'h0), mk(32'h3001, 1'b0, 32'h0), 1'b1, 1'b0, 1'b1, 0, 2'b00);
        step(2'b11, mk(32'h3002, 1'b0, 32'h0), mk(32'h3003, 1'b0, 32'h0), 1'b1, 1'b0, 1'b1, 2, 2'b00);
        step(2'b10, z, mk(32'h3004, 1'b0, 32'h0), 1'b1, 1'b0, 1'b1, 4, 2'b00);
        step(2'b11, mk(32'h3EEE, 1'b0, 32'h0), mk(32'h3FFF, 1'b0, 32'h0), 1'b0, 1'b1, 1'b1, 5, 2'b00);
        step(2'b00, z, z, 1'b0, 1'b0, 1'b1, 0, 2'b00);
        step(2'b00, z, z, 1'b0, 1'b0, 1'b1, 0, 2'b00);

        // Random traffic across several pointer wraps.
        for (int i = 0; i < 80; i++)
            step(2'($urandom_range(0, 3)),
                 mk($urandom, ($urandom_range(0, 7) == 0), $urandom),
                 mk($urandom, 1'($urandom_range(0, 1)), $urandom),
                 ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 0, 2'b00);
        for (int i = 0; i < 5; i++)
            step(2'b00, z, z, 1'b0, 1'b0, 1'b0, 0, 2'b00);

        // Asynchronous reset mid-operation.
        step(2'b11, mk(32'h4000, 1'b0, 32'h0), mk(32'h4001, 1'b0, 32'h0), 1'b1, 1'b0, 1'b1, 0, 2'b00);
        dec_stall = 1'b0;
        in_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 128'(out_count), 128'(0));
        chk("arst_valid", 128'(out_inst_valid), 128'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(2'b00, z, z, 1'b0, 1'b0, 1'b1, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
